// File: rtl/la_hs_pkg.sv
// Shared definitions for the la_hs req/ack bundled-data crossing (transmitter and receiver).
package la_hs_pkg;

  // 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  localparam int LA_HS_STAGES = 2;

endpackage

// File: rtl/la_dsync.sv
// Level synchronizer: din appears on dout exactly STAGES clk cycles later. No reset, so a level held
// across a reset stays visible to the logic that follows.
module la_dsync #(
  parameter int STAGES = 2,
  parameter     PROP   = "DEFAULT"
) (
  input  logic clk,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    sync <= {sync[STAGES-2:0], din};
  end

  assign dout = sync[STAGES-1];

  // Hook for a technology-specific synchronizer cell selected by PROP.
  generate
    if (PROP != "DEFAULT") begin : g_prop_hook
    end
  endgenerate

endmodule

// File: rtl/la_hs_tx.sv
// Source half of a 4-phase req/ack CDC: the word is held on data_out while req_out is high; ack edges act STAGES+1 cycles later.
// in_ready stays low until the full handshake completes and ack_sync is low; LA_HS_TX_TIMEOUT_EN adds a sticky err output.
module la_hs_tx
  import la_hs_pkg::*;
#(
  parameter int DW      = 32,
  parameter int STAGES  = LA_HS_STAGES,
`ifdef LA_HS_TX_TIMEOUT_EN
  parameter int TIMEOUT = 1024,
`endif
  parameter     PROP    = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          req_out,
  output logic [DW-1:0] data_out,
  input  logic          ack_in,
  output logic          tx_done,
  output logic          busy
`ifdef LA_HS_TX_TIMEOUT_EN
  ,
  output logic          err
`endif
);

  state_t state;
  logic   ack_sync;
  logic   accept;

  la_dsync #(
    .STAGES(STAGES),
    .PROP  (PROP)
  ) u_ack_sync (
    .clk (clk),
    .din (ack_in),
    .dout(ack_sync)
  );

  // A leftover ack (e.g. from before a reset) must drain before a new request.
  assign in_ready = (state == IDLE) & ~ack_sync;
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            data_out <= in_data;
            req_out  <= 1'b1;
            state    <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_sync) begin
            req_out <= 1'b0;
            state   <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_sync) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          req_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef LA_HS_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] phase_cnt;
  logic          phase_end;
  logic          in_phase;

  assign in_phase  = (state == REQ_HI) | (state == REQ_LO);
  assign phase_end = accept | ((state == REQ_HI) & ack_sync) | ((state == REQ_LO) & ~ack_sync);

  // err rises in the cycle the count reaches TIMEOUT; the handshake keeps waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt <= '0;
      err       <= 1'b0;
    end else if (phase_end || !in_phase) begin
      phase_cnt <= '0;
    end else begin
      if (phase_cnt != CW'(TIMEOUT)) phase_cnt <= phase_cnt + 1'b1;
      if (phase_cnt >= CW'(TIMEOUT - 1)) err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_la_hs_tx.sv
// Directed bench for la_hs_tx: a scoreboard checks data_out against queued words on every tx_done.
module tb_la_hs_tx;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data  = 32'h0;
  logic        ack_man  = 1'b0;
  logic        auto_en  = 1'b0;
  logic [2:0]  dly      = 3'b000;
  logic        ack_in;
  logic        in_ready;
  logic        req_out;
  logic [31:0] data_out;
  logic        tx_done;
  logic        busy;
`ifdef LA_HS_TX_TIMEOUT_EN
  logic        err;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];

  la_hs_tx #(
    .DW    (32),
    .STAGES(2)
`ifdef LA_HS_TX_TIMEOUT_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .req_out (req_out),
    .data_out(data_out),
    .ack_in  (ack_in),
    .tx_done (tx_done),
    .busy    (busy)
`ifdef LA_HS_TX_TIMEOUT_EN
    ,
    .err     (err)
`endif
  );

  always #5 clk = ~clk;

  // Automatic destination: ack_in echoes req_out three cycles later.
  always @(posedge clk) dly <= {dly[1:0], req_out};
  assign ack_in = auto_en ? dly[2] : ack_man;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int target, input string name);
    for (int k = 0; k < 100 && done_cnt < target; k++) tick();
    chk(name, 32'(done_cnt >= target), 32'd1);
  endtask

  // Scoreboard monitor.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && tx_done) begin
        done_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: tx_done with data_out %0h, expected no completion", data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e) begin
            n_fail++;
            $display("FAIL sb_data: got %0h, expected %0h", data_out, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    int          idx;
    int          base;
    int          viol;
    logic [31:0] words[3];
    words[0] = 32'h1;
    words[1] = 32'h2;
    words[2] = 32'h3;

    // Reset state
    repeat (4) tick();
    chk("rst_req", 32'(req_out), 32'd0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Single transfer: accept at c=0, ack_in high c=3..6
    for (int c = 0; c <= 12; c++) begin
      in_valid = (c == 0);
      in_data  = 32'hDEADBEEF;
      ack_man  = (c >= 3 && c <= 6);
      if (c == 0) exp_q.push_back(32'hDEADBEEF);
      chk($sformatf("t1_req_c%0d", c), 32'(req_out), 32'(c >= 1 && c <= 5));
      chk($sformatf("t1_done_c%0d", c), 32'(tx_done), 32'(c == 10));
      chk($sformatf("t1_rdy_c%0d", c), 32'(in_ready), 32'(c == 0 || c >= 10));
      chk($sformatf("t1_data_c%0d", c), data_out, (c >= 1) ? 32'hDEADBEEF : 32'h0);
      tick();
    end
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // Back-to-back with automatic responder
    base     = done_cnt;
    idx      = 0;
    viol     = 0;
    auto_en  = 1'b1;
    in_valid = 1'b1;
    in_data  = words[0];
    for (int k = 0; k < 300 && done_cnt < base + 3; k++) begin
      acc = in_valid && in_ready;
      if (in_ready && busy) viol++;
      tick();
      if (acc) begin
        exp_q.push_back(words[idx]);
        idx++;
        if (idx < 3) in_data = words[idx];
        else in_valid = 1'b0;
      end
    end
    chk("t2_done_cnt", 32'(done_cnt - base), 32'd3);
    chk("t2_accepts", 32'(idx), 32'd3);
    chk("t2_rdy_busy", 32'(viol), 32'd0);
    chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);
    auto_en = 1'b0;
    repeat (4) tick();

    // Stuck ack across reset, in_valid already high
    reset    = 1'b1;
    ack_man  = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hA5A5A5A5;
    repeat (4) tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_rdy_k%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("t3_req_k%0d", k), 32'(req_out), 32'd0);
      tick();
    end
    ack_man = 1'b0;
    chk("t3_rdy_b0", 32'(in_ready), 32'd0);
    tick();
    chk("t3_rdy_b1", 32'(in_ready), 32'd0);
    chk("t3_req_b1", 32'(req_out), 32'd0);
    tick();
    chk("t3_rdy_b2", 32'(in_ready), 32'd1);
    chk("t3_req_b2", 32'(req_out), 32'd0);
    exp_q.push_back(32'hA5A5A5A5);
    tick();
    in_valid = 1'b0;
    chk("t3_req_b3", 32'(req_out), 32'd1);
    chk("t3_busy_b3", 32'(busy), 32'd1);
    base    = done_cnt;
    auto_en = 1'b1;
    wait_done(base + 1, "t3_complete");
    auto_en = 1'b0;
    repeat (3) tick();

    // Reset while in REQ_HI with ack_in high
    chk("t4_rdy_pre", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    tick();
    in_valid = 1'b0;
    chk("t4_req_hi", 32'(req_out), 32'd1);
    ack_man = 1'b1;
    tick();
    chk("t4_busy_hi", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_req_rst", 32'(req_out), 32'd0);
    chk("t4_busy_rst", 32'(busy), 32'd0);
    chk("t4_rdy_rst", 32'(in_ready), 32'd0);
    chk("t4_data_rst", data_out, 32'h0);
    repeat (2) tick();
    chk("t4_rdy_hold", 32'(in_ready), 32'd0);
    ack_man = 1'b0;
    tick();
    chk("t4_rdy_b1", 32'(in_ready), 32'd0);
    tick();
    chk("t4_rdy_b2", 32'(in_ready), 32'd1);
    tick();
    chk("t4_rdy_b3", 32'(in_ready), 32'd1);
    chk("t4_req_b3", 32'(req_out), 32'd0);

    // ack_in low pulse while in REQ_HI, new word offered while busy
    in_valid = 1'b1;
    in_data  = 32'h55AA55AA;
    exp_q.push_back(32'h55AA55AA);
    tick();
    in_data = 32'hFFFF0000;
    for (int k = 0; k < 6; k++) begin
      ack_man = 1'b0;
      chk($sformatf("t5_req_k%0d", k), 32'(req_out), 32'd1);
      chk($sformatf("t5_busy_k%0d", k), 32'(busy), 32'd1);
      chk($sformatf("t5_data_k%0d", k), data_out, 32'h55AA55AA);
      tick();
    end
    in_valid = 1'b0;
    base     = done_cnt;
    auto_en  = 1'b1;
    wait_done(base + 1, "t5_complete");
    auto_en = 1'b0;
    repeat (3) tick();

`ifdef LA_HS_TX_TIMEOUT_EN
    // Timeout: ack_in never answers
    chk("t6_rdy_pre", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 32'hC0FFEE00;
    tick();
    in_valid = 1'b0;
    ack_man  = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k == 0 || k == 15) chk($sformatf("t6_err_k%0d", k), 32'(err), 32'd0);
      if (k == 16 || k == 20) chk($sformatf("t6_err_k%0d", k), 32'(err), 32'd1);
      if (k == 20) chk("t6_req_k20", 32'(req_out), 32'd1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_err_rst", 32'(err), 32'd0);
    tick();
`endif

    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
